sp_ram_mbist: RTL



---
 rtl/sp_ram_mbist.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sp_ram_mbist.sv
// March C- memory BIST master for a single-port SRAM with 1-cycle read latency.
// It walks every word with six elements and captures the first read mismatch.
module sp_ram_mbist #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic [DATA_WIDTH-1:0]   fail_data_o,
  output logic [DATA_WIDTH-1:0]   fail_exp_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int WA = ADDR_WIDTH - 2;
  localparam int N  = RAM_SIZE / 4;
  localparam logic [WA-1:0] WLAST = WA'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;

  state_e          state_q, state_d;
  elem_e           elem_q, elem_d;
  logic [WA-1:0]   waddr_q, waddr_d;
  logic            phase_q, phase_d;
  logic            cmp_vld_q;
  logic [WA-1:0]   cmp_addr_q;
  logic [DATA_WIDTH-1:0] cmp_exp_q;
  logic            fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_exp_q;

  logic two_cyc, desc, last, is_wr, is_rd, start_clr, mismatch;
  logic [DATA_WIDTH-1:0] rd_exp;

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    waddr_d   = waddr_q;
    phase_d   = phase_q;
    two_cyc   = (elem_q == E1) || (elem_q == E2) || (elem_q == E3) || (elem_q == E4);
    desc      = (elem_q == E3) || (elem_q == E4);
    last      = desc ? (waddr_q == '0) : (waddr_q == WLAST);
    is_wr     = (state_q == RUN) && ((elem_q == E0) || (two_cyc && phase_q));
    is_rd     = (state_q == RUN) && !is_wr;
    rd_exp    = ((elem_q == E2) || (elem_q == E4)) ? '1 : '0;
    start_clr = ((state_q == IDLE) || (state_q == DONE)) && start_i;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          elem_d  = E0;
          waddr_d = '0;
          phase_d = 1'b0;
        end
      end
      RUN: begin
        if (two_cyc && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!last) begin
            waddr_d = desc ? waddr_q - WA'(1) : waddr_q + WA'(1);
          end else begin
            // Element hand-off: jump straight to the start address of the next element
            case (elem_q)
              E0:      begin elem_d = E1; waddr_d = '0;    end
              E1:      begin elem_d = E2; waddr_d = '0;    end
              E2:      begin elem_d = E3; waddr_d = WLAST; end
              E3:      begin elem_d = E4; waddr_d = WLAST; end
              E4:      begin elem_d = E5; waddr_d = '0;    end
              default: state_d = DRAIN;
            endcase
          end
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign mismatch = cmp_vld_q && (mem_rdata_i != cmp_exp_q);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= IDLE;
      elem_q      <= E0;
      waddr_q     <= '0;
      phase_q     <= 1'b0;
      cmp_vld_q   <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      waddr_q   <= waddr_d;
      phase_q   <= phase_d;
      cmp_vld_q <= is_rd;
      if (start_clr) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_data_q <= '0;
        fail_exp_q  <= '0;
      end else if (mismatch && !fail_q) begin
        fail_q      <= 1'b1;
        fail_addr_q <= {cmp_addr_q, 2'b00};
        fail_data_q <= mem_rdata_i;
        fail_exp_q  <= cmp_exp_q;
      end
    end
  end

  // Read-side pipeline stage: remember what this read should return
  always_ff @(posedge clk) begin
    if (is_rd) begin
      cmp_addr_q <= waddr_q;
      cmp_exp_q  <= rd_exp;
    end
  end

  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign fail_exp_o  = fail_exp_q;
  assign mem_en_o    = (state_q == RUN);
  assign mem_we_o    = is_wr;
  assign mem_addr_o  = {waddr_q, 2'b00};
  assign mem_wdata_o = (is_wr && ((elem_q == E1) || (elem_q == E3))) ? '1 : '0;
  assign mem_be_o    = mem_en_o ? '1 : '0;
endmodule
